// File: rtl/countdown_timer_bcd.sv
// BCD mm:ss countdown timer with IDLE/RUN/PAUSE/DONE control and registered outputs.
// Define COUNTDOWN_ALARM_EN to hold DONE with a latched alarm until start_stop or load.
module countdown_timer_bcd #(
    parameter logic [3:0] SEC_TENS_LIMIT = 4'd5,
    parameter logic [3:0] MIN_TENS_LIMIT = 4'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        start_stop,
    input  logic        load,
    input  logic [15:0] init_value,
    output logic [15:0] value,
    output logic        borrow,
    output logic        running,
    output logic        done,
    output logic        alarm
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] value_next;
    logic        borrow_next;
    logic        done_next;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        return {clamp_digit(v[15:12], MIN_TENS_LIMIT), clamp_digit(v[11:8], 4'd9),
                clamp_digit(v[7:4], SEC_TENS_LIMIT), clamp_digit(v[3:0], 4'd9)};
    endfunction

    // Ripple-borrow decrement; a zero digit reloads to its own limit.
    function automatic logic [15:0] dec_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else begin
            r[3:0] = 4'd9;
            if (v[7:4] != 4'd0) begin
                r[7:4] = v[7:4] - 4'd1;
            end else begin
                r[7:4] = SEC_TENS_LIMIT;
                if (v[11:8] != 4'd0) begin
                    r[11:8] = v[11:8] - 4'd1;
                end else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = (v[15:12] != 4'd0) ? v[15:12] - 4'd1 : MIN_TENS_LIMIT;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_next  = state;
        value_next  = value;
        borrow_next = 1'b0;
        done_next   = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    value_next = clamp_bcd(init_value);
                end else if (start_stop && value != 16'h0000) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // Reaching 0000 is recognised one cycle after the final tick.
                if (value == 16'h0000) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else if (start_stop) begin
                    state_next = PAUSE;
                end else if (en) begin
                    value_next  = dec_bcd(value);
                    borrow_next = (value[11:0] == 12'h000);
                end
            end
            PAUSE: begin
                if (load) begin
                    value_next = clamp_bcd(init_value);
                    state_next = IDLE;
                end else if (start_stop) begin
                    state_next = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    value_next = clamp_bcd(init_value);
                    state_next = IDLE;
`ifdef COUNTDOWN_ALARM_EN
                end else if (start_stop) begin
                    state_next = IDLE;
                end
`else
                end else begin
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            value   <= clamp_bcd(init_value);
            borrow  <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            value   <= value_next;
            borrow  <= borrow_next;
            running <= (state_next == RUN);
            done    <= done_next;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm <= 1'b0;
        end else begin
            alarm <= (state_next == DONE);
        end
    end
`else
    assign alarm = 1'b0;
`endif

endmodule

// File: doc/countdown_timer_bcd.md
COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

Interface
REQ-001 SHALL have parameter SEC_TENS_LIMIT, default 4'd5, max value of seconds-tens digit.
REQ-002 SHALL have parameter MIN_TENS_LIMIT, default 4'd5, max value of minutes-tens digit.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count tick enable (1 Hz strobe, one clk wide).
REQ-006 SHALL have port start_stop  input  1  single-cycle pulse, start/pause/resume.
REQ-007 SHALL have port load  input  1  single-cycle pulse, reload from init_value.
REQ-008 SHALL have port init_value  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
REQ-009 SHALL have port value  output  16  current BCD count, same digit order as init_value.
REQ-010 SHALL have port borrow  output  1  one-cycle pulse on each minutes-ones borrow into minutes-tens.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when count reaches 0000.
REQ-013 SHALL have port alarm  output  1  latched end-of-count indicator (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE; all outputs registered.
REQ-015 SHALL, in IDLE: start_stop with value != 0000 -> RUN; start_stop with value == 0000 -> stay IDLE.
REQ-016 SHALL, in RUN: start_stop -> PAUSE; in PAUSE: start_stop -> RUN.
REQ-017 SHALL decrement value by one second per en cycle in RUN only; en ignored in IDLE/PAUSE/DONE.
REQ-018 SHALL decrement per digit: digit 0 reloads to its limit (sec_ones 9, sec_tens SEC_TENS_LIMIT, min_ones 9, min_tens MIN_TENS_LIMIT) and borrows from next digit; otherwise digit-1.
REQ-019 SHALL, when a RUN decrement yields 0000, enter DONE next cycle and assert done for exactly that one cycle; never decrement from 0000.
REQ-020 SHALL assert borrow for one cycle whenever min_ones wraps 0 -> 9 during a decrement.
REQ-021 SHALL accept load in IDLE, PAUSE, DONE: value <= init_value next cycle, state -> IDLE; load ignored in RUN.
REQ-022 SHALL clamp on load any init_value digit exceeding its limit to that limit (e.g. sec_tens 7 loads as SEC_TENS_LIMIT).
REQ-023 SHALL, on simultaneous start_stop and en in RUN, pause and discard that tick (value unchanged).
REQ-024 SHALL, on simultaneous load and start_stop in IDLE/PAUSE/DONE, give load priority; state -> IDLE.
REQ-025 SHALL, on simultaneous load and en in RUN, apply the tick and ignore load.

Reset
REQ-026 SHALL, on reset low, immediately set state IDLE, value = clamped init_value, borrow/running/done/alarm = 0, regardless of state mid-count.
REQ-027 SHALL resume normal operation on first rising clk edge after reset deasserts.

Configuration
REQ-028 SHALL use macro COUNTDOWN_ALARM_EN.
REQ-029 SHALL, with COUNTDOWN_ALARM_EN defined: alarm set on entering DONE, held high in DONE; start_stop or load clears alarm and returns IDLE (load also reloads).
REQ-030 SHALL, without COUNTDOWN_ALARM_EN: alarm tied 0; DONE lasts one cycle then auto-returns to IDLE with value 0000.

Verification
REQ-031 init_value=16'h0003, load, start_stop, 3 en ticks -> value 0002,0001,0000; done pulse 1 cycle after 0000; running falls.
REQ-032 value=16'h1000, RUN, 1 en tick -> value 16'h0959, borrow=1 one cycle.
REQ-033 RUN at 16'h0130, start_stop+en same cycle -> PAUSE, value stays 0130; 5 en ticks -> unchanged; start_stop -> RUN.
REQ-034 init_value=16'h9999 (defaults), load -> value 16'h5959.
REQ-035 RUN at 16'h0042, reset low mid-count -> state IDLE, value = init_value, all flags 0 same cycle.
REQ-036 ALARM_EN defined, count to 0000 -> alarm=1 held 10 cycles; start_stop -> alarm=0, IDLE; without macro alarm stays 0 and IDLE after 1 cycle.
